id_ex_pipe_reg: RTL and testbench

//  ID/EX pipeline register directly downstream of the register file.

---
 rtl/id_ex_pipe_reg.sv | 219 +++++++++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_reg
// -----------------------------------------------------------------------------
// Purpose:
//    ID/EX pipeline register that sits directly after the register file.
//    It captures both read operands, the source/destination indices, the
//    immediate and an opaque control bundle on every clock. It also:
//      - detects a load-use hazard against the instruction already in EX and
//        stalls ID for one cycle by loading a bubble into EX,
//      - kills the ID instruction on a branch flush,
//      - keeps a saturating count of load-use stall cycles for perf debug.
//
// Configuration macro:
//    WB_BYPASS_EN - when defined, a write-back to the register being read in
//                   the same cycle is forwarded into ex_A / ex_B on capture.
//                   When undefined, ReadData1/ReadData2 are captured as-is.
//
// Parameters:
//    CTRL_W - width of the EX/MEM/WB control bundle carried through
//    CNT_W  - width of the saturating stall counter
//
// Ports:
//    clk, reset                      clock, synchronous active-high reset
//    id_valid                        ID holds a real instruction
//    ReadRegister1/2, ReadData1/2    register file read indices and data
//    id_Rd, id_imm, id_ctrl          ID destination, immediate, control
//    id_MemRead                      ID instruction is a load
//    flush                           branch taken, kill the ID instruction
//    RegWrite, WriteRegister,
//    WriteData                       write-back port of the register file
//    stall_id                        combinational: hold PC and IF/ID
//    ex_valid, ex_A, ex_B, ex_Rn,
//    ex_Rm, ex_Rd, ex_imm, ex_ctrl,
//    ex_MemRead                      registered EX-stage fields
//    stall_cnt                       load-use stall cycles since reset
// -----------------------------------------------------------------------------
module id_ex_pipe_reg #(
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [4:0]        ReadRegister1,
   input  logic [4:0]        ReadRegister2,
   input  logic [63:0]       ReadData1,
   input  logic [63:0]       ReadData2,
   input  logic [4:0]        id_Rd,
   input  logic [63:0]       id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              id_MemRead,
   input  logic              flush,
   input  logic              RegWrite,
   input  logic [4:0]        WriteRegister,
   input  logic [63:0]       WriteData,
   output logic              stall_id,
   output logic              ex_valid,
   output logic [63:0]       ex_A,
   output logic [63:0]       ex_B,
   output logic [4:0]        ex_Rn,
   output logic [4:0]        ex_Rm,
   output logic [4:0]        ex_Rd,
   output logic [63:0]       ex_imm,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic              ex_MemRead,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [4:0] ZERO_REG = 5'd31;

   typedef struct packed {
      logic              valid;
      logic [63:0]       a;
      logic [63:0]       b;
      logic [4:0]        rn;
      logic [4:0]        rm;
      logic [4:0]        rd;
      logic [63:0]       imm;
      logic [CTRL_W-1:0] ctrl;
      logic              mem_read;
   } ex_stage_t;

   // Bubble: no instruction, all indices pointing at the zero register so
   // downstream forwarding compares can never match it.
   function automatic ex_stage_t bubble_f();
      ex_stage_t b;
      b.valid    = 1'b0;
      b.a        = 64'd0;
      b.b        = 64'd0;
      b.rn       = ZERO_REG;
      b.rm       = ZERO_REG;
      b.rd       = ZERO_REG;
      b.imm      = 64'd0;
      b.ctrl     = {CTRL_W{1'b0}};
      b.mem_read = 1'b0;
      return b;
   endfunction

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc_f(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (&v) begin
         r = v;
      end else begin
         r = v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

   ex_stage_t        ex_q;
   ex_stage_t        ex_d;
   ex_stage_t        capture_s;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;
   logic             hazard_s;
   logic [63:0]      operand_a_s;
   logic [63:0]      operand_b_s;

`ifdef WB_BYPASS_EN
   // Same-cycle register-file write/read: forward the write-back data.
   always_comb begin
      operand_a_s = ReadData1;
      operand_b_s = ReadData2;
      if (RegWrite && (WriteRegister != ZERO_REG) && (WriteRegister == ReadRegister1)) begin
         operand_a_s = WriteData;
      end else begin
         operand_a_s = ReadData1;
      end
      if (RegWrite && (WriteRegister != ZERO_REG) && (WriteRegister == ReadRegister2)) begin
         operand_b_s = WriteData;
      end else begin
         operand_b_s = ReadData2;
      end
   end
`else
   // Without bypass the write-back port only feeds the register file itself.
   logic unused_wb_s;
   assign unused_wb_s = ^{RegWrite, WriteRegister, WriteData};

   // Operands pass straight from the register file.
   always_comb begin
      operand_a_s = ReadData1;
      operand_b_s = ReadData2;
   end
`endif

   // Load-use hazard: EX holds a real load whose (non-zero) destination is
   // read by the real instruction in ID.
   always_comb begin
      hazard_s = ex_q.valid && ex_q.mem_read && (ex_q.rd != ZERO_REG) && id_valid &&
                 ((ex_q.rd == ReadRegister1) || (ex_q.rd == ReadRegister2));
   end

   // Stall only when the hazard actually wins; a flushed instruction is
   // dropped rather than held.
   always_comb begin
      if (reset || flush) begin
         stall_id = 1'b0;
      end else begin
         stall_id = hazard_s;
      end
   end

   // Pack the ID-side fields into the EX stage layout.
   always_comb begin
      capture_s          = bubble_f();
      capture_s.valid    = 1'b1;
      capture_s.a        = operand_a_s;
      capture_s.b        = operand_b_s;
      capture_s.rn       = ReadRegister1;
      capture_s.rm       = ReadRegister2;
      capture_s.rd       = id_Rd;
      capture_s.imm      = id_imm;
      capture_s.ctrl     = id_ctrl;
      capture_s.mem_read = id_MemRead;
   end

   // Next-state selection: flush > hazard > capture (reset handled in the flop).
   always_comb begin
      ex_d        = ex_q;
      stall_cnt_d = stall_cnt_q;
      if (flush) begin
         ex_d = bubble_f();
      end else if (hazard_s) begin
         ex_d        = bubble_f();
         stall_cnt_d = sat_inc_f(stall_cnt_q);
      end else if (id_valid) begin
         ex_d = capture_s;
      end else begin
         ex_d = bubble_f();
      end
   end

   // EX register and stall counter with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q        <= bubble_f();
         stall_cnt_q <= {CNT_W{1'b0}};
      end else begin
         ex_q        <= ex_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Outputs come straight from the flops.
   always_comb begin
      ex_valid   = ex_q.valid;
      ex_A       = ex_q.a;
      ex_B       = ex_q.b;
      ex_Rn      = ex_q.rn;
      ex_Rm      = ex_q.rm;
      ex_Rd      = ex_q.rd;
      ex_imm     = ex_q.imm;
      ex_ctrl    = ex_q.ctrl;
      ex_MemRead = ex_q.mem_read;
      stall_cnt  = stall_cnt_q;
   end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

   logic        clk;
   logic        reset;
   logic        id_valid;
   logic [4:0]  ReadRegister1;
   logic [4:0]  ReadRegister2;
   logic [63:0] ReadData1;
   logic [63:0] ReadData2;
   logic [4:0]  id_Rd;
   logic [63:0] id_imm;
   logic [7:0]  id_ctrl;
   logic        id_MemRead;
   logic        flush;
   logic        RegWrite;
   logic [4:0]  WriteRegister;
   logic [63:0] WriteData;

   logic        stall_id;
   logic        ex_valid;
   logic [63:0] ex_A;
   logic [63:0] ex_B;
   logic [4:0]  ex_Rn;
   logic [4:0]  ex_Rm;
   logic [4:0]  ex_Rd;
   logic [63:0] ex_imm;
   logic [7:0]  ex_ctrl;
   logic        ex_MemRead;
   logic [31:0] stall_cnt;

   // Second instance with a 2-bit counter, sharing the stimulus, to reach saturation.
   logic        s_stall_id;
   logic        s_ex_valid;
   logic [63:0] s_ex_A;
   logic [63:0] s_ex_B;
   logic [4:0]  s_ex_Rn;
   logic [4:0]  s_ex_Rm;
   logic [4:0]  s_ex_Rd;
   logic [63:0] s_ex_imm;
   logic [7:0]  s_ex_ctrl;
   logic        s_ex_MemRead;
   logic [1:0]  s_stall_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   id_ex_pipe_reg #(.CTRL_W(8), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
      .ReadData1(ReadData1), .ReadData2(ReadData2),
      .id_Rd(id_Rd), .id_imm(id_imm), .id_ctrl(id_ctrl), .id_MemRead(id_MemRead),
      .flush(flush), .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
      .stall_id(stall_id), .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B),
      .ex_Rn(ex_Rn), .ex_Rm(ex_Rm), .ex_Rd(ex_Rd), .ex_imm(ex_imm),
      .ex_ctrl(ex_ctrl), .ex_MemRead(ex_MemRead), .stall_cnt(stall_cnt)
   );

   id_ex_pipe_reg #(.CTRL_W(8), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
      .ReadData1(ReadData1), .ReadData2(ReadData2),
      .id_Rd(id_Rd), .id_imm(id_imm), .id_ctrl(id_ctrl), .id_MemRead(id_MemRead),
      .flush(flush), .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
      .stall_id(s_stall_id), .ex_valid(s_ex_valid), .ex_A(s_ex_A), .ex_B(s_ex_B),
      .ex_Rn(s_ex_Rn), .ex_Rm(s_ex_Rm), .ex_Rd(s_ex_Rd), .ex_imm(s_ex_imm),
      .ex_ctrl(s_ex_ctrl), .ex_MemRead(s_ex_MemRead), .stall_cnt(s_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      id_valid      = 1'b0;
      ReadRegister1 = 5'd0;
      ReadRegister2 = 5'd0;
      ReadData1     = 64'd0;
      ReadData2     = 64'd0;
      id_Rd         = 5'd0;
      id_imm        = 64'd0;
      id_ctrl       = 8'd0;
      id_MemRead    = 1'b0;
      flush         = 1'b0;
      RegWrite      = 1'b0;
      WriteRegister = 5'd0;
      WriteData     = 64'd0;
   endtask

   // Present a load to ID: destination rd, reading X1/X2.
   task automatic drive_load(input logic [4:0] rd);
      drive_idle();
      id_valid      = 1'b1;
      id_MemRead    = 1'b1;
      id_Rd         = rd;
      ReadRegister1 = 5'd1;
      ReadRegister2 = 5'd2;
   endtask

   task automatic test_reset();
      drive_idle();
      reset = 1'b1;
      tick();
      tick();
      n_checks++; if (ex_valid !== 1'b0) $display("FAIL rst_valid: got %0h exp 0", ex_valid); else n_pass++;
      n_checks++; if (ex_A !== 64'd0) $display("FAIL rst_A: got %0h exp 0", ex_A); else n_pass++;
      n_checks++; if (ex_B !== 64'd0) $display("FAIL rst_B: got %0h exp 0", ex_B); else n_pass++;
      n_checks++; if (ex_imm !== 64'd0) $display("FAIL rst_imm: got %0h exp 0", ex_imm); else n_pass++;
      n_checks++; if (ex_ctrl !== 8'd0) $display("FAIL rst_ctrl: got %0h exp 0", ex_ctrl); else n_pass++;
      n_checks++; if (ex_MemRead !== 1'b0) $display("FAIL rst_memread: got %0h exp 0", ex_MemRead); else n_pass++;
      n_checks++; if (ex_Rd !== 5'd31) $display("FAIL rst_Rd: got %0d exp 31", ex_Rd); else n_pass++;
      n_checks++; if (ex_Rn !== 5'd31) $display("FAIL rst_Rn: got %0d exp 31", ex_Rn); else n_pass++;
      n_checks++; if (ex_Rm !== 5'd31) $display("FAIL rst_Rm: got %0d exp 31", ex_Rm); else n_pass++;
      n_checks++; if (stall_cnt !== 32'd0) $display("FAIL rst_cnt: got %0d exp 0", stall_cnt); else n_pass++;
      n_checks++; if (stall_id !== 1'b0) $display("FAIL rst_stall: got %0h exp 0", stall_id); else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_capture();
      drive_idle();
      id_valid      = 1'b1;
      ReadRegister1 = 5'd2;
      ReadRegister2 = 5'd3;
      ReadData1     = 64'hA;
      ReadData2     = 64'hB;
      id_Rd         = 5'd5;
      id_imm        = 64'hFFFF_FFFF_FFFF_FFF0;
      id_ctrl       = 8'h5A;
      tick();
      n_checks++; if (ex_A !== 64'hA) $display("FAIL cap_A: got %0h exp a", ex_A); else n_pass++;
      n_checks++; if (ex_B !== 64'hB) $display("FAIL cap_B: got %0h exp b", ex_B); else n_pass++;
      n_checks++; if (ex_Rd !== 5'd5) $display("FAIL cap_Rd: got %0d exp 5", ex_Rd); else n_pass++;
      n_checks++; if (ex_Rn !== 5'd2) $display("FAIL cap_Rn: got %0d exp 2", ex_Rn); else n_pass++;
      n_checks++; if (ex_Rm !== 5'd3) $display("FAIL cap_Rm: got %0d exp 3", ex_Rm); else n_pass++;
      n_checks++; if (ex_imm !== 64'hFFFF_FFFF_FFFF_FFF0) $display("FAIL cap_imm: got %0h exp fffffffffffffff0", ex_imm); else n_pass++;
      n_checks++; if (ex_ctrl !== 8'h5A) $display("FAIL cap_ctrl: got %0h exp 5a", ex_ctrl); else n_pass++;
      n_checks++; if (ex_valid !== 1'b1) $display("FAIL cap_valid: got %0h exp 1", ex_valid); else n_pass++;
      // Invalid ID instruction must enter EX as a bubble even with fields set.
      id_valid = 1'b0;
      tick();
      n_checks++; if (ex_valid !== 1'b0) $display("FAIL inv_valid: got %0h exp 0", ex_valid); else n_pass++;
      n_checks++; if (ex_Rd !== 5'd31) $display("FAIL inv_Rd: got %0d exp 31", ex_Rd); else n_pass++;
      n_checks++; if (ex_A !== 64'd0) $display("FAIL inv_A: got %0h exp 0", ex_A); else n_pass++;
   endtask

   task automatic test_load_use();
      // Hazard through Rn.
      drive_load(5'd4);
      tick();
      n_checks++; if (ex_MemRead !== 1'b1) $display("FAIL lu_memread: got %0h exp 1", ex_MemRead); else n_pass++;
      drive_idle();
      id_valid      = 1'b1;
      ReadRegister1 = 5'd4;
      ReadRegister2 = 5'd6;
      ReadData1     = 64'h44;
      ReadData2     = 64'h66;
      id_Rd         = 5'd8;
      #1;
      n_checks++; if (stall_id !== 1'b1) $display("FAIL lu_stall: got %0h exp 1", stall_id); else n_pass++;
      tick();
      n_checks++; if (ex_valid !== 1'b0) $display("FAIL lu_bubble: got %0h exp 0", ex_valid); else n_pass++;
      n_checks++; if (ex_Rd !== 5'd31) $display("FAIL lu_bubble_Rd: got %0d exp 31", ex_Rd); else n_pass++;
      n_checks++; if (stall_cnt !== 32'd1) $display("FAIL lu_cnt: got %0d exp 1", stall_cnt); else n_pass++;
      n_checks++; if (stall_id !== 1'b0) $display("FAIL lu_stall_once: got %0h exp 0", stall_id); else n_pass++;
      tick();
      n_checks++; if (ex_valid !== 1'b1) $display("FAIL lu_held_valid: got %0h exp 1", ex_valid); else n_pass++;
      n_checks++; if (ex_Rd !== 5'd8) $display("FAIL lu_held_Rd: got %0d exp 8", ex_Rd); else n_pass++;
      n_checks++; if (ex_A !== 64'h44) $display("FAIL lu_held_A: got %0h exp 44", ex_A); else n_pass++;
      n_checks++; if (stall_cnt !== 32'd1) $display("FAIL lu_cnt_hold: got %0d exp 1", stall_cnt); else n_pass++;
      // Hazard through Rm.
      drive_load(5'd9);
      tick();
      drive_idle();
      id_valid      = 1'b1;
      ReadRegister1 = 5'd10;
      ReadRegister2 = 5'd9;
      id_Rd         = 5'd11;
      #1;
      n_checks++; if (stall_id !== 1'b1) $display("FAIL lu_rm_stall: got %0h exp 1", stall_id); else n_pass++;
      tick();
      n_checks++; if (stall_cnt !== 32'd2) $display("FAIL lu_rm_cnt: got %0d exp 2", stall_cnt); else n_pass++;
      tick();
   endtask

   task automatic test_flush();
      drive_load(5'd4);
      tick();
      drive_idle();
      id_valid      = 1'b1;
      ReadRegister1 = 5'd4;
      ReadRegister2 = 5'd6;
      id_Rd         = 5'd8;
      flush         = 1'b1;
      #1;
      n_checks++; if (stall_id !== 1'b0) $display("FAIL fl_stall: got %0h exp 0", stall_id); else n_pass++;
      tick();
      n_checks++; if (ex_valid !== 1'b0) $display("FAIL fl_bubble: got %0h exp 0", ex_valid); else n_pass++;
      n_checks++; if (stall_cnt !== 32'd2) $display("FAIL fl_cnt: got %0d exp 2", stall_cnt); else n_pass++;
      flush = 1'b0;
      tick();
   endtask

   task automatic test_x31();
      drive_load(5'd31);
      tick();
      drive_idle();
      id_valid      = 1'b1;
      ReadRegister1 = 5'd31;
      ReadRegister2 = 5'd31;
      id_Rd         = 5'd12;
      #1;
      n_checks++; if (stall_id !== 1'b0) $display("FAIL x31_stall: got %0h exp 0", stall_id); else n_pass++;
      tick();
      n_checks++; if (ex_valid !== 1'b1) $display("FAIL x31_valid: got %0h exp 1", ex_valid); else n_pass++;
      n_checks++; if (stall_cnt !== 32'd2) $display("FAIL x31_cnt: got %0d exp 2", stall_cnt); else n_pass++;
      // Matching index but no real instruction in ID: no stall.
      drive_load(5'd13);
      tick();
      drive_idle();
      ReadRegister1 = 5'd13;
      #1;
      n_checks++; if (stall_id !== 1'b0) $display("FAIL novalid_stall: got %0h exp 0", stall_id); else n_pass++;
      tick();
   endtask

   task automatic test_bypass();
      logic [63:0] exp_a;
`ifdef WB_BYPASS_EN
      exp_a = 64'h55;
`else
      exp_a = 64'h0;
`endif
      drive_idle();
      id_valid      = 1'b1;
      RegWrite      = 1'b1;
      WriteRegister = 5'd7;
      WriteData     = 64'h55;
      ReadRegister1 = 5'd7;
      ReadData1     = 64'h0;
      ReadRegister2 = 5'd8;
      ReadData2     = 64'h77;
      id_Rd         = 5'd14;
      tick();
      n_checks++; if (ex_A !== exp_a) $display("FAIL byp_A: got %0h exp %0h", ex_A, exp_a); else n_pass++;
      n_checks++; if (ex_B !== 64'h77) $display("FAIL byp_B_nomatch: got %0h exp 77", ex_B); else n_pass++;
      // Write to X31 is never forwarded.
      WriteRegister = 5'd31;
      ReadRegister1 = 5'd31;
      ReadData1     = 64'h99;
      tick();
      n_checks++; if (ex_A !== 64'h99) $display("FAIL byp_x31: got %0h exp 99", ex_A); else n_pass++;
      drive_idle();
      tick();
   endtask

   // One complete load-use sequence ending with the held instruction captured.
   task automatic run_hazard(input logic [4:0] rd);
      drive_load(rd);
      tick();
      drive_idle();
      id_valid      = 1'b1;
      ReadRegister1 = rd;
      id_Rd         = 5'd20;
      tick();
      tick();
   endtask

   task automatic test_saturation();
      // Two hazards so far; the 2-bit counter reaches 3 and then sticks.
      n_checks++; if (s_stall_cnt !== 2'd2) $display("FAIL sat_pre: got %0d exp 2", s_stall_cnt); else n_pass++;
      run_hazard(5'd15);
      n_checks++; if (s_stall_cnt !== 2'd3) $display("FAIL sat_max: got %0d exp 3", s_stall_cnt); else n_pass++;
      n_checks++; if (stall_cnt !== 32'd3) $display("FAIL cnt_3: got %0d exp 3", stall_cnt); else n_pass++;
      run_hazard(5'd16);
      n_checks++; if (s_stall_cnt !== 2'd3) $display("FAIL sat_nowrap: got %0d exp 3", s_stall_cnt); else n_pass++;
      n_checks++; if (stall_cnt !== 32'd4) $display("FAIL cnt_4: got %0d exp 4", stall_cnt); else n_pass++;
      // Reset clears the counter again.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++; if (stall_cnt !== 32'd0) $display("FAIL cnt_rst: got %0d exp 0", stall_cnt); else n_pass++;
   endtask

   initial begin
      reset = 1'b1;
      drive_idle();
      test_reset();
      test_capture();
      test_load_use();
      test_flush();
      test_x31();
      test_bypass();
      test_saturation();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
